uart_recv_cfg: RTL and testbench
================================

// Module: uart_recv_cfg
// PURPOSE
//  Parametrised UART receiver for the host link: configurable data width, parity
//  and stop bits. Adds a 2-flop input synchroniser, majority-vote sampling and
//  false-start rejection. Per-frame parity/framing/overrun flags and a 1-deep
//  valid/ready output register feed the command decoder.
// PARAMETERS
//  WAIT_CYCLES  10  clk cycles per bit (27 MHz -> 2.7 Mbaud); must be >= 4
//  DATA_BITS    8   data bits per frame, 5..9, LSB first
//  PARITY       0   0 = none, 1 = odd, 2 = even
//  STOP_BITS    1   1 or 2
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-high reset
//  uartRx        in   1          async serial line, idle high
//  rxData        out  DATA_BITS  received word, valid while rxValid=1
//  rxValid       out  1          word held in output register
//  rxReady       in   1          consumer accepts; transfer when rxValid & rxReady
//  rxParityErr   out  1          parity mismatch on held word (0 when PARITY=0)
//  rxFrameErr    out  1          a stop bit sampled low on held word
//  rxOverrun     out  1          held word overwrote an unaccepted word
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counter 0; synchroniser flops and 3-sample
//   vote history preset to 1 so no false start. Reset mid-frame aborts the frame
//   with no rxValid.
//  rxS = uartRx after 2 flops (2-cycle delay). vote = majority of the last 3 rxS.
//  States:
//   IDLE:  rxS==0 -> START, counter=1.
//   START: at counter==WAIT_CYCLES/2, vote==1 -> IDLE (glitch rejected);
//          otherwise -> DATA, counter=1.
//   DATA:  at counter==WAIT_CYCLES, shift vote in LSB-first, counter=1. After
//          DATA_BITS bits -> PARITY if PARITY!=0, else STOP.
//   PARITY: at counter==WAIT_CYCLES, pErr = (XOR(data, vote) != (PARITY==1)).
//   STOP:  one sample per stop bit at counter==WAIT_CYCLES; any low -> fErr.
//          After the last stop sample, commit the frame. Exit to BREAK if the
//          last stop bit sampled low and all data bits were 0; otherwise -> IDLE.
//   BREAK: wait for rxS==1, then -> IDLE. No frames are emitted while in BREAK.
//  Commit (one cycle after the last stop sample): rxData, rxParityErr,
//   rxFrameErr load; rxValid=1.
//  rxOverrun=1 if rxValid was 1 and not accepted in the same cycle; otherwise 0.
//  Simultaneous accept and commit: new word loads, rxValid stays 1, rxOverrun=0.
//  Accept with no commit: rxValid and all flags clear next cycle.
//  Latency: rxValid rises 2 + WAIT_CYCLES/2 + (DATA_BITS + (PARITY!=0) +
//   STOP_BITS)*WAIT_CYCLES + 1 cycles after the uartRx falling edge.
//   Defaults: 98 cycles.
//  Back-to-back frames: a start edge is detectable in the cycle after the last
//   stop sample, so no idle time is required between frames.
//  Counter width is $clog2(WAIT_CYCLES+1). Bit counter wraps at
//   DATA_BITS + parity + STOP_BITS.
// TESTING
//  Defaults, send 0xA5 with rxReady=1 -> rxValid rises 98 clk after the start
//   edge; rxData=0xA5; all flags 0; rxValid high for 1 cycle.
//  Low pulse of 3 clk on uartRx -> no rxValid; state back in IDLE; the next
//   frame 0x3C is received correctly.
//  PARITY=2, send 0x07 with parity bit 0 -> rxData=0x07, rxParityErr=1; the
//   same frame with parity bit 1 -> rxParityErr=0.
//  Hold uartRx low for 30 bit times, then release -> exactly one word:
//   rxData=0x00, rxFrameErr=1; then 0x55 -> rxData=0x55, flags 0.
//  rxReady=0, frames 0x11 then 0x22 -> second word is rxData=0x22 with
//   rxOverrun=1; rxReady pulsed in the commit cycle -> rxOverrun=0.
//  DATA_BITS=7, STOP_BITS=2: second stop bit low on 0x5A -> rxFrameErr=1;
//   reset asserted mid-frame -> no rxValid, outputs 0.

Source files
------------

// File: rtl/uart_recv_cfg.sv
// uart_recv_cfg: UART receiver with configurable width, parity and stop bits.
// Synchronised, majority-voted sampling feeding a 1-deep valid/ready output register.
module uart_recv_cfg #(
    parameter int WAIT_CYCLES = 10,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uartRx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    input  logic                 rxReady,
    output logic                 rxParityErr,
    output logic                 rxFrameErr,
    output logic                 rxOverrun
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam int NB = DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d, hist_q, hist_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 valid_q, valid_d, pflag_q, pflag_d, fflag_q, fflag_d, ovr_q, ovr_d;
    logic                 rx_s, vote, tick, half, last, commit, accept, ferr_now;

    assign rxData      = data_q;
    assign rxValid     = valid_q;
    assign rxParityErr = pflag_q;
    assign rxFrameErr  = fflag_q;
    assign rxOverrun   = ovr_q;

    always_comb begin
        rx_s     = sync_q[1];
        vote     = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
        tick     = cnt_q == CW'(WAIT_CYCLES);
        half     = cnt_q == CW'(WAIT_CYCLES / 2);
        last     = bit_q == BW'(NB - 1);
        ferr_now = ferr_q | ~vote;
        commit   = state_q == STOP && tick && last;
        accept   = valid_q & rxReady;
        sync_d   = {sync_q[0], uartRx};
        hist_d   = {hist_q[0], rx_s};
        state_d  = state_q;
        cnt_d    = (state_q == IDLE || state_q == BRK) ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = CW'(1);
                bit_d   = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
            end
            START: if (half) begin
                state_d = vote ? IDLE : DATA;
                cnt_d   = CW'(1);
            end
            DATA: if (tick) begin
                shift_d = {vote, shift_q[DATA_BITS-1:1]};
                cnt_d   = CW'(1);
                bit_d   = bit_q + BW'(1);
                if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (tick) begin
                perr_d  = (^shift_q ^ vote) != (PARITY == 1);
                cnt_d   = CW'(1);
                bit_d   = bit_q + BW'(1);
                state_d = STOP;
            end
            STOP: if (tick) begin
                ferr_d = ferr_now;
                cnt_d  = CW'(1);
                bit_d  = last ? '0 : bit_q + BW'(1);
                // A low final stop over an all-zero word is a line break: park until the line recovers
                if (last) state_d = (!vote && shift_q == '0) ? BRK : IDLE;
            end
            BRK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = commit | (valid_q & ~rxReady);
        data_d  = commit ? shift_q : data_q;
        pflag_d = commit ? perr_q : (accept ? 1'b0 : pflag_q);
        fflag_d = commit ? ferr_now : (accept ? 1'b0 : fflag_q);
        ovr_d   = commit ? (valid_q & ~rxReady) : (accept ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            hist_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pflag_q <= 1'b0;
            fflag_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pflag_q <= pflag_d;
            fflag_q <= fflag_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_recv_cfg.sv
// tb_uart_recv_cfg: scoreboard bench for uart_recv_cfg in three configurations.
// All instances share one serial line; each scenario targets one instance.
module tb_uart_recv_cfg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       v0, v1, v2, p0, p1, p2, f0, f1, f2, o0, o1, o2;
    int         tests = 0;
    int         fails = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs0[$], obs1[$], obs2[$];

    always #5 clk = ~clk;

    uart_recv_cfg dut0 (
        .clk(clk), .reset(reset), .uartRx(uart_rx), .rxData(d0), .rxValid(v0),
        .rxReady(rdy0), .rxParityErr(p0), .rxFrameErr(f0), .rxOverrun(o0)
    );
    uart_recv_cfg #(.PARITY(2)) dut1 (
        .clk(clk), .reset(reset), .uartRx(uart_rx), .rxData(d1), .rxValid(v1),
        .rxReady(rdy1), .rxParityErr(p1), .rxFrameErr(f1), .rxOverrun(o1)
    );
    uart_recv_cfg #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .uartRx(uart_rx), .rxData(d2), .rxValid(v2),
        .rxReady(rdy2), .rxParityErr(p2), .rxFrameErr(f2), .rxOverrun(o2)
    );

    // Every completed transfer is recorded as {overrun, frame, parity, data}
    always @(negedge clk) begin
        if (v0 && rdy0) obs0.push_back({o0, f0, p0, 1'b0, d0});
        if (v1 && rdy1) obs1.push_back({o1, f1, p1, 1'b0, d1});
        if (v2 && rdy2) obs2.push_back({o2, f2, p2, 2'b00, d2});
    end

    task automatic bit_time;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] d, input int db, input int pbit, input int nstop, input logic [1:0] stops);
        uart_rx = 1'b0;
        bit_time();
        for (int i = 0; i < db; i++) begin
            uart_rx = d[i];
            bit_time();
        end
        if (pbit >= 0) begin
            uart_rx = pbit[0];
            bit_time();
        end
        for (int i = 0; i < nstop; i++) begin
            uart_rx = stops[i];
            bit_time();
        end
        uart_rx = 1'b1;
    endtask

    task automatic take(input int w, output logic [11:0] got, output bit ok);
        ok = 1'b0;
        got = '0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (w == 0 && obs0.size() > 0) begin got = obs0.pop_front(); ok = 1'b1; end
            else if (w == 1 && obs1.size() > 0) begin got = obs1.pop_front(); ok = 1'b1; end
            else if (w == 2 && obs2.size() > 0) begin got = obs2.pop_front(); ok = 1'b1; end
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        uart_rx = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        obs0.delete(); obs1.delete(); obs2.delete(); exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({v0, p0, f0, o0, d0} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 000", {v0, p0, f0, o0, d0});
        end
        repeat (150) @(posedge clk);
        #1;
        tests++;
        if (obs0.size() != 0 || v0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got words=%0d valid=%b expected words=0 valid=0", obs0.size(), v0);
        end
    endtask

    task automatic test_latency;
        int lat;
        logic after;
        logic [11:0] got, e;
        bit ok;
        do_reset();
        exp_q.push_back({3'b000, 9'h0A5});
        fork
            send_frame(9'h0A5, 8, -1, 1, 2'b11);
            begin
                lat = 0;
                while (lat < 200 && v0 !== 1'b1) begin @(posedge clk); #1; lat++; end
                @(posedge clk);
                #1 after = v0;
            end
        join
        tests++;
        if (lat != 98) begin fails++; $display("FAIL latency: got %0d cycles expected 98", lat); end
        tests++;
        if (after !== 1'b0) begin fails++; $display("FAIL valid_width: got valid=%b one cycle later expected 0", after); end
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL word_a5: got %h (seen=%0b) expected %h", got, ok, e); end
    endtask

    task automatic test_glitch;
        logic [11:0] got, e;
        bit ok;
        do_reset();
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (obs0.size() != 0 || v0 !== 1'b0) begin
            fails++;
            $display("FAIL glitch_word: got words=%0d valid=%b expected none", obs0.size(), v0);
        end
        tests++;
        if (dut0.state_q !== 3'd0) begin fails++; $display("FAIL glitch_idle: got state %0d expected 0", dut0.state_q); end
        exp_q.push_back({3'b000, 9'h03C});
        send_frame(9'h03C, 8, -1, 1, 2'b11);
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL glitch_next: got %h (seen=%0b) expected %h", got, ok, e); end
    endtask

    task automatic test_parity;
        logic [11:0] got, e;
        bit ok;
        do_reset();
        exp_q.push_back({3'b001, 9'h007});
        exp_q.push_back({3'b000, 9'h007});
        send_frame(9'h007, 8, 0, 1, 2'b11);
        send_frame(9'h007, 8, 1, 1, 2'b11);
        take(1, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL parity_bad: got %h (seen=%0b) expected %h", got, ok, e); end
        take(1, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL parity_good: got %h (seen=%0b) expected %h", got, ok, e); end
    endtask

    task automatic test_break;
        logic [11:0] got, e;
        bit ok;
        do_reset();
        exp_q.push_back({3'b010, 9'h000});
        uart_rx = 1'b0;
        repeat (300) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL break_word: got %h (seen=%0b) expected %h", got, ok, e); end
        tests++;
        if (obs0.size() != 0) begin fails++; $display("FAIL break_count: got %0d extra words expected 0", obs0.size()); end
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 8, -1, 1, 2'b11);
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL break_next: got %h (seen=%0b) expected %h", got, ok, e); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] got, e, snap;
        bit ok;
        do_reset();
        rdy0 = 1'b0;
        exp_q.push_back({3'b100, 9'h022});
        send_frame(9'h011, 8, -1, 1, 2'b11);
        send_frame(9'h022, 8, -1, 1, 2'b11);
        repeat (5) @(posedge clk);
        #1 snap = {o0, f0, p0, 1'b0, d0};
        e = exp_q.pop_front();
        tests++;
        if (v0 !== 1'b1 || snap !== e) begin fails++; $display("FAIL overrun_held: got valid=%b %h expected valid=1 %h", v0, snap, e); end
        exp_q.push_back({3'b100, 9'h022});
        exp_q.push_back({3'b000, 9'h033});
        fork
            send_frame(9'h033, 8, -1, 1, 2'b11);
            begin
                repeat (97) @(posedge clk);
                #1 rdy0 = 1'b1;
                @(posedge clk);
                #1 rdy0 = 1'b0;
                snap = {o0, f0, p0, 1'b0, d0};
            end
        join
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL overrun_accepted: got %h (seen=%0b) expected %h", got, ok, e); end
        e = exp_q.pop_front();
        tests++;
        if (snap !== e) begin fails++; $display("FAIL commit_accept: got %h expected %h", snap, e); end
        tests++;
        if (v0 !== 1'b1) begin fails++; $display("FAIL commit_valid: got valid=%b expected 1", v0); end
        exp_q.push_back({3'b000, 9'h033});
        rdy0 = 1'b1;
        take(0, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL drain: got %h (seen=%0b) expected %h", got, ok, e); end
    endtask

    task automatic test_stop2;
        logic [11:0] got, e, snap;
        bit ok;
        do_reset();
        exp_q.push_back({3'b010, 9'h05A});
        send_frame(9'h05A, 7, -1, 2, 2'b01);
        take(2, got, ok);
        e = exp_q.pop_front();
        tests++;
        if (!ok || got !== e) begin fails++; $display("FAIL stop2_ferr: got %h (seen=%0b) expected %h", got, ok, e); end
        rdy2 = 1'b0;
        exp_q.push_back({3'b000, 9'h021});
        send_frame(9'h021, 7, -1, 2, 2'b11);
        repeat (5) @(posedge clk);
        #1 snap = {o2, f2, p2, 2'b00, d2};
        e = exp_q.pop_front();
        tests++;
        if (v2 !== 1'b1 || snap !== e) begin fails++; $display("FAIL stop2_held: got valid=%b %h expected valid=1 %h", v2, snap, e); end
        uart_rx = 1'b0;
        repeat (35) @(posedge clk);
        #1 reset = 1'b1;
        uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tests++;
        if ({v2, p2, f2, o2, d2} !== 11'h000) begin
            fails++;
            $display("FAIL midframe_reset: got %h expected 000", {v2, p2, f2, o2, d2});
        end
        rdy2 = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        tests++;
        if (obs2.size() != 0 || v2 !== 1'b0) begin
            fails++;
            $display("FAIL midframe_word: got words=%0d valid=%b expected none", obs2.size(), v2);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_parity();
        test_break();
        test_back_to_back();
        test_stop2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
